// File: rtl/pci_bus_master.sv
// PCI-style bus initiator: requests the bus and runs one address phase plus
// 1..MAX_BURST data phases, then releases the bus through a turnaround cycle.
// All bus control signals are active-low.
module pci_bus_master #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_BURST      = 4,
    parameter int unsigned DEVSEL_TIMEOUT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] addr,
    input  logic [2:0]        num_words,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic              REQ,
    input  logic              GNT,
    input  logic              frame_in,
    input  logic              irdy_in,
    output logic              FRAME_out,
    output logic              IRDY_out,
    output logic              ctl_oe,
    output logic [DATA_W-1:0] AD_out,
    input  logic [DATA_W-1:0] AD_in,
    output logic              ad_oe,
    output logic [3:0]        CBE_out,
    input  logic              TRDY,
    input  logic              DEVSEL
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned TMR_W = $clog2(DEVSEL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_WAIT,
        S_ADDR,
        S_DATA,
        S_ABORT,
        S_TURN
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [TMR_W-1:0]    timer, timer_d;
    logic                devsel_seen, devsel_seen_d;
    logic                aborted, aborted_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [DATA_W-1:0]   addr_q, addr_d;

    logic                req_d, frame_d, irdy_d, ctl_oe_d, ad_oe_d;
    logic [DATA_W-1:0]   ad_d, rd_data_d;
    logic [3:0]          cbe_d;
    logic                rd_valid_d, busy_d, done_d, abort_d;

    logic                num_ok;
    logic                is_write;
    logic                xfer;

    assign num_ok   = (num_words != 3'd0) && (32'(num_words) <= MAX_BURST);
    assign is_write = cmd_q[0];
    assign xfer     = !IRDY_out && !TRDY && !DEVSEL;

    // State register and registered outputs; reset releases the bus at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            timer       <= '0;
            devsel_seen <= 1'b0;
            aborted     <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            REQ         <= 1'b1;
            FRAME_out   <= 1'b1;
            IRDY_out    <= 1'b1;
            ctl_oe      <= 1'b0;
            ad_oe       <= 1'b0;
            AD_out      <= '0;
            CBE_out     <= 4'hF;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            abort       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            timer       <= timer_d;
            devsel_seen <= devsel_seen_d;
            aborted     <= aborted_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            REQ         <= req_d;
            FRAME_out   <= frame_d;
            IRDY_out    <= irdy_d;
            ctl_oe      <= ctl_oe_d;
            ad_oe       <= ad_oe_d;
            AD_out      <= ad_d;
            CBE_out     <= cbe_d;
            rd_data     <= rd_data_d;
            rd_valid    <= rd_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            abort       <= abort_d;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        timer_d       = timer;
        devsel_seen_d = devsel_seen;
        aborted_d     = aborted;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        req_d         = REQ;
        frame_d       = FRAME_out;
        irdy_d        = IRDY_out;
        ctl_oe_d      = ctl_oe;
        ad_oe_d       = ad_oe;
        ad_d          = AD_out;
        cbe_d         = CBE_out;
        rd_data_d     = rd_data;
        rd_valid_d    = 1'b0;
        busy_d        = busy;
        done_d        = 1'b0;
        abort_d       = 1'b0;
        wr_pop        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && num_ok) begin
                    cmd_d     = cmd;
                    addr_d    = addr;
                    cnt_d     = CNT_W'(num_words);
                    aborted_d = 1'b0;
                    req_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_REQ_WAIT;
                end
            end

            // Only a grant on an idle bus starts the address phase.
            S_REQ_WAIT: begin
                if (!GNT && frame_in && irdy_in) begin
                    frame_d  = 1'b0;
                    ctl_oe_d = 1'b1;
                    ad_oe_d  = 1'b1;
                    ad_d     = addr_q;
                    cbe_d    = cmd_q;
                    req_d    = 1'b1;
                    state_d  = S_ADDR;
                end
            end

            S_ADDR: begin
                irdy_d        = 1'b0;
                cbe_d         = 4'h0;
                timer_d       = '0;
                devsel_seen_d = 1'b0;
                if (is_write) begin
                    ad_d   = wr_data;
                    wr_pop = 1'b1;
                end else begin
                    ad_oe_d = 1'b0;
                end
                if (cnt == CNT_W'(1)) begin
                    frame_d = 1'b1;
                end
                state_d = S_DATA;
            end

            S_DATA: begin
                if (!DEVSEL) begin
                    devsel_seen_d = 1'b1;
                end
                if (xfer) begin
                    cnt_d = cnt - CNT_W'(1);
                    if (!is_write) begin
                        rd_data_d  = AD_in;
                        rd_valid_d = 1'b1;
                    end else if (cnt > CNT_W'(1)) begin
                        ad_d   = wr_data;
                        wr_pop = 1'b1;
                    end
                    if (cnt == CNT_W'(2)) begin
                        frame_d = 1'b1;
                    end
                    if (FRAME_out) begin
                        irdy_d  = 1'b1;
                        state_d = S_TURN;
                    end
                end else if (DEVSEL && !devsel_seen) begin
                    timer_d = timer + TMR_W'(1);
                    if (timer_d == TMR_W'(DEVSEL_TIMEOUT)) begin
                        frame_d = 1'b1;
                        state_d = S_ABORT;
                    end
                end
            end

            // Master abort: drop IRDY one cycle after FRAME, flag for the done pulse.
            S_ABORT: begin
                irdy_d    = 1'b1;
                aborted_d = 1'b1;
                state_d   = S_TURN;
            end

            S_TURN: begin
                ctl_oe_d = 1'b0;
                ad_oe_d  = 1'b0;
                cbe_d    = 4'hF;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                abort_d  = aborted;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pci_bus_master.sv
// Directed bench for pci_bus_master: write, burst read, busy bus, master
// abort, reset mid-burst and illegal/overlapping start requests.
module tb_pci_bus_master;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] addr;
    logic [2:0]        num_words;
    logic [DATA_W-1:0] wr_data;
    logic              wr_pop;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              abort;
    logic              REQ;
    logic              GNT;
    logic              frame_in;
    logic              irdy_in;
    logic              FRAME_out;
    logic              IRDY_out;
    logic              ctl_oe;
    logic [DATA_W-1:0] AD_out;
    logic [DATA_W-1:0] AD_in;
    logic              ad_oe;
    logic [3:0]        CBE_out;
    logic              TRDY;
    logic              DEVSEL;

    logic              ext_frame;
    logic              ext_irdy;

    int n_checks = 0;
    int n_fail   = 0;

    // Resolved bus: our drivers when enabled, otherwise another master / pull-ups.
    assign frame_in = ctl_oe ? FRAME_out : ext_frame;
    assign irdy_in  = ctl_oe ? IRDY_out  : ext_irdy;

    pci_bus_master #(
        .DATA_W(32), .MAX_BURST(4), .DEVSEL_TIMEOUT(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr),
        .num_words(num_words), .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .abort(abort), .REQ(REQ), .GNT(GNT), .frame_in(frame_in),
        .irdy_in(irdy_in), .FRAME_out(FRAME_out), .IRDY_out(IRDY_out),
        .ctl_oe(ctl_oe), .AD_out(AD_out), .AD_in(AD_in), .ad_oe(ad_oe),
        .CBE_out(CBE_out), .TRDY(TRDY), .DEVSEL(DEVSEL)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(negedge clk);
    endtask

    // Present a start strobe for one cycle.
    task automatic launch(input logic [3:0] c, input logic [31:0] a, input logic [2:0] n);
        start = 1'b1; cmd = c; addr = a; num_words = n;
        step();
        start = 1'b0;
    endtask

    logic [31:0] rd_words [4];
    logic        trdy_seq [6];
    int          widx;
    int          nrd;
    int          ndone;

    initial begin
        rst = 1'b1; start = 1'b0; cmd = 4'h0; addr = '0; num_words = 3'd0;
        wr_data = '0; GNT = 1'b1; ext_frame = 1'b1; ext_irdy = 1'b1;
        AD_in = '0; TRDY = 1'b1; DEVSEL = 1'b1;
        step(); step();
        check("rst_req", REQ, 1);
        check("rst_frame", FRAME_out, 1);
        check("rst_irdy", IRDY_out, 1);
        check("rst_oe", {ctl_oe, ad_oe}, 0);
        check("rst_cbe", CBE_out, 4'hF);
        check("rst_ad", AD_out, 0);
        check("rst_flags", {busy, done, abort, rd_valid}, 0);
        rst = 1'b0;
        step();

        // ---- single write ----
        launch(4'h7, 32'h1000, 3'd1);
        check("w1_req", REQ, 0);
        check("w1_busy", busy, 1);
        step();
        check("w1_wait_req", REQ, 0);
        check("w1_wait_oe", ctl_oe, 0);
        GNT = 1'b0; wr_data = 32'hAAAA_0001;
        step();
        check("w1_addr_frame", FRAME_out, 0);
        check("w1_addr_oe", {ctl_oe, ad_oe}, 2'b11);
        check("w1_addr_ad", AD_out, 32'h1000);
        check("w1_addr_cbe", CBE_out, 4'h7);
        check("w1_addr_req", REQ, 1);
        check("w1_addr_pop", wr_pop, 1);
        GNT = 1'b1; TRDY = 1'b0; DEVSEL = 1'b0;
        step();
        check("w1_data_ad", AD_out, 32'hAAAA_0001);
        check("w1_data_frame", FRAME_out, 1);
        check("w1_data_irdy", IRDY_out, 0);
        check("w1_data_cbe", CBE_out, 4'h0);
        check("w1_data_pop", wr_pop, 0);
        step();
        TRDY = 1'b1; DEVSEL = 1'b1;
        check("w1_turn_irdy", IRDY_out, 1);
        check("w1_turn_oe", ctl_oe, 1);
        check("w1_turn_done", done, 0);
        step();
        check("w1_done", {done, abort, busy}, 3'b100);
        check("w1_release", {ctl_oe, ad_oe}, 0);
        check("w1_cbe", CBE_out, 4'hF);
        step();
        check("w1_done_pulse", done, 0);

        // ---- burst read with two wait states before word 2 ----
        rd_words[0] = 32'hD000_0010; rd_words[1] = 32'hD000_0021;
        rd_words[2] = 32'hD000_0032; rd_words[3] = 32'hD000_0043;
        trdy_seq[0] = 1'b0; trdy_seq[1] = 1'b1; trdy_seq[2] = 1'b1;
        trdy_seq[3] = 1'b0; trdy_seq[4] = 1'b0; trdy_seq[5] = 1'b0;
        GNT = 1'b0;
        launch(4'h6, 32'h2000, 3'd4);
        step();
        check("rd_addr_ad", AD_out, 32'h2000);
        check("rd_addr_cbe", CBE_out, 4'h6);
        GNT = 1'b1;
        step();
        check("rd_turnaround_adoe", ad_oe, 0);
        check("rd_irdy", IRDY_out, 0);
        widx = 0; nrd = 0;
        for (int c = 0; c < 6; c++) begin
            TRDY = trdy_seq[c]; DEVSEL = 1'b0; AD_in = rd_words[widx];
            step();
            check("rd_valid", rd_valid, !trdy_seq[c]);
            if (rd_valid) begin
                check("rd_data", rd_data, rd_words[nrd]);
                nrd++;
            end
            if (!trdy_seq[c]) widx++;
            if (c == 4) begin
                check("rd_frame_after3", FRAME_out, 1);
                check("rd_irdy_after3", IRDY_out, 0);
            end
            if (c == 3) check("rd_frame_after2", FRAME_out, 0);
        end
        TRDY = 1'b1; DEVSEL = 1'b1;
        check("rd_irdy_after4", IRDY_out, 1);
        step();
        check("rd_count", nrd, 4);
        check("rd_done", done, 1);

        // ---- busy bus: grant while another master owns the bus ----
        ext_frame = 1'b0; GNT = 1'b0;
        launch(4'h7, 32'h3000, 3'd2);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bb_req", REQ, 0);
            check("bb_oe", ctl_oe, 0);
        end
        ext_frame = 1'b1;
        step();
        check("bb_addr_oe", ctl_oe, 1);
        check("bb_addr_frame", FRAME_out, 0);
        GNT = 1'b1; TRDY = 1'b0; DEVSEL = 1'b0; wr_data = 32'hBEEF_0000;
        step();
        check("bb_w0", AD_out, 32'hBEEF_0000);
        check("bb_frame0", FRAME_out, 0);
        wr_data = 32'hBEEF_0001;
        check("bb_pop_mid", wr_pop, 1);
        step();
        check("bb_w1", AD_out, 32'hBEEF_0001);
        check("bb_frame1", FRAME_out, 1);
        check("bb_pop_last", wr_pop, 0);
        step();
        check("bb_turn_irdy", IRDY_out, 1);
        TRDY = 1'b1; DEVSEL = 1'b1;
        step();
        check("bb_done", done, 1);

        // ---- master abort: DEVSEL never asserted ----
        GNT = 1'b0; TRDY = 1'b0; DEVSEL = 1'b1;
        launch(4'h6, 32'h4000, 3'd2);
        step();
        GNT = 1'b1;
        step();
        for (int c = 1; c <= 4; c++) begin
            step();
            check("ma_frame_hold", FRAME_out, 0);
        end
        step();
        check("ma_frame_up", FRAME_out, 1);
        check("ma_irdy_low", IRDY_out, 0);
        step();
        check("ma_irdy_up", IRDY_out, 1);
        check("ma_no_done_yet", {done, abort}, 0);
        step();
        check("ma_done_abort", {done, abort, busy}, 3'b110);
        check("ma_no_rd", rd_valid, 0);
        step();
        check("ma_abort_pulse", abort, 0);

        // ---- reset in the middle of a read burst ----
        GNT = 1'b0; TRDY = 1'b0; DEVSEL = 1'b0; AD_in = 32'h5555_0000;
        launch(4'h6, 32'h5000, 3'd4);
        step();
        GNT = 1'b1;
        step();
        step();
        check("rm_first_word", rd_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; TRDY = 1'b1; DEVSEL = 1'b1;
        check("rm_oe", {ctl_oe, ad_oe}, 0);
        check("rm_req_busy", {REQ, busy}, 2'b10);
        check("rm_ctl", {FRAME_out, IRDY_out}, 2'b11);
        check("rm_cbe", CBE_out, 4'hF);
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            if (done) ndone++;
            step();
        end
        check("rm_no_done", ndone, 0);

        // ---- illegal word counts and a start during a burst ----
        GNT = 1'b1;
        launch(4'h7, 32'h6000, 3'd0);
        check("il_zero", {REQ, busy}, 2'b10);
        launch(4'h7, 32'h6000, 3'd5);
        check("il_five", {REQ, busy}, 2'b10);
        GNT = 1'b0; TRDY = 1'b0; DEVSEL = 1'b0;
        launch(4'h7, 32'h7000, 3'd2);
        step();
        GNT = 1'b1;
        launch(4'h6, 32'h8000, 3'd1);
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) ndone++;
            step();
        end
        check("ov_one_done", ndone, 1);
        check("ov_idle", {REQ, busy}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
